branch_resolve_queue: RTL
=========================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of in-flight branch entries (power of 2, >= 2).
REQ-002 SHALL have parameter PC_W, default INSTR_MEM_IDX_W from general_defines, width of stored branch PC.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port alloc_valid  input  1  fetch requests allocation of a predicted branch.
REQ-006 SHALL have port alloc_pc  input  PC_W  branch PC at fetch.
REQ-007 SHALL have port alloc_pred_taken  input  1  prediction issued at fetch.
REQ-008 SHALL have port alloc_ready  output  1  allocation accepted this cycle if alloc_valid high.
REQ-009 SHALL have port alloc_tag  output  $clog2(DEPTH)  tail index assigned to the allocating branch.
REQ-010 SHALL have port res_valid  input  1  execute reports a resolved branch.
REQ-011 SHALL have port res_tag  input  $clog2(DEPTH)  tag of the resolved branch.
REQ-012 SHALL have port res_taken  input  1  actual outcome.
REQ-013 SHALL have port update_valid  output  1  predictor training strobe.
REQ-014 SHALL have port update_pc  output  PC_W  PC of the retired branch.
REQ-015 SHALL have port actual_taken  output  1  outcome of the retired branch.
REQ-016 SHALL have port mispredict  output  1  retired branch had pred != actual.

Function
REQ-017 SHALL hold a circular buffer of DEPTH entries {valid, resolved, pc, pred, actual}, with head/tail pointers wrapping modulo DEPTH and an occupancy count 0..DEPTH.
REQ-018 SHALL drive alloc_ready = (count != DEPTH); a pop in the same cycle does not free a slot for allocation while full.
REQ-019 SHALL drive alloc_tag = tail combinationally; on alloc_valid && alloc_ready, write entry[tail] = {1,0,alloc_pc,alloc_pred_taken,0} and advance tail.
REQ-020 SHALL, on res_valid with entry[res_tag].valid=1 and resolved=0, set resolved=1 and actual=res_taken; a resolve to an invalid or already-resolved entry is ignored.
REQ-021 SHALL allow resolves in any order; retirement is strictly in order from head, at most one per cycle.
REQ-022 SHALL retire the head when entry[head].valid && resolved in cycle N: clear valid, advance head, and in cycle N+1 drive update_valid=1 with update_pc, actual_taken, mispredict = (pred != actual) for that entry.
REQ-023 SHALL drive update_valid=0 and mispredict=0 in any cycle that does not follow a retirement.
REQ-024 SHALL not bypass: a resolve to the head in cycle N makes it retirable in N+1 at the earliest (update_valid in N+2).
REQ-025 SHALL on simultaneous allocate and retire leave count unchanged; allocate alone +1; retire alone -1.

Reset
REQ-026 SHALL on rst clear all valid/resolved bits, head=tail=0, count=0, and drive update_valid=0, mispredict=0, update_pc=0, actual_taken=0 in the following cycle.
REQ-027 SHALL make rst override all concurrent allocate, resolve and retire activity, discarding in-flight entries.

Configuration
REQ-028 SHALL, with BRQ_MISPRED_FLUSH_EN defined, flush the entire queue (all valid=0, head=tail=0, count=0) at the edge retiring a mispredicting head, force alloc_ready=0 in that cycle, and ignore res_valid in that cycle.
REQ-029 SHALL, without BRQ_MISPRED_FLUSH_EN, never flush; mispredicting entries retire like others and mispredict is reported only.

Verification
REQ-030 Alloc pc=0x04 pred=1, resolve tag 0 taken=1 -> update_valid two cycles after resolve, update_pc=0x04, actual_taken=1, mispredict=0.
REQ-031 Alloc tags 0,1,2; resolve order 2,0,1 -> updates emitted in order pc(0),pc(1),pc(2), one per cycle, none before tag 0 resolves.
REQ-032 Fill DEPTH=8 entries -> alloc_ready=0; retire one with alloc_valid held -> no alloc that cycle, alloc accepted next cycle with alloc_tag=0 (wrap).
REQ-033 With BRQ_MISPRED_FLUSH_EN: alloc 3, resolve all, head pred=1 actual=0 -> mispredict=1 once, count=0, no further updates; without macro -> three updates, first with mispredict=1.
REQ-034 Assert rst with 5 entries, 3 resolved -> next cycle alloc_ready=1, alloc_tag=0, update_valid=0, no stale updates afterwards.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
//
// Purpose:
//   Tracks predicted branches from fetch until execute resolves them. Branches
//   resolve in any order, but they retire strictly in program order from the
//   head, at most one per cycle. Each retirement produces a one-cycle
//   predictor training strobe in the following cycle.
//
// Optional feature (compile-time macro BRQ_MISPRED_FLUSH_EN):
//   When this macro is defined, retiring a mispredicted head also flushes the
//   whole queue at that edge. In the flush cycle allocation is refused and
//   res_valid is ignored. When it is undefined, mispredicts are only reported.
//
// Parameters:
//   DEPTH - number of in-flight entries (power of 2, >= 2)
//   PC_W  - stored branch PC width (matches the instruction memory index width)
//
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   alloc_valid      - fetch requests an entry for a predicted branch
//   alloc_pc         - branch PC
//   alloc_pred_taken - prediction issued at fetch
//   alloc_ready      - entry available; allocation happens when valid && ready
//   alloc_tag        - index the allocating branch receives (current tail)
//   res_valid        - execute reports a resolved branch
//   res_tag          - tag of the resolved branch
//   res_taken        - actual outcome
//   update_valid     - training strobe, one cycle after a retirement
//   update_pc        - PC of the retired branch
//   actual_taken     - outcome of the retired branch
//   mispredict       - retired branch had prediction != outcome
//
// Handshake: the alloc channel uses valid/ready. A transfer occurs on a rising
// edge where alloc_valid && alloc_ready are both high. alloc_ready and
// alloc_tag depend only on internal state, never on alloc_valid. The resolve
// channel has no back-pressure: it is sampled whenever res_valid is high.
// ---------------------------------------------------------------------------
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic [PC_W-1:0]          alloc_pc,
  input  logic                     alloc_pred_taken,
  output logic                     alloc_ready,
  output logic [$clog2(DEPTH)-1:0] alloc_tag,
  input  logic                     res_valid,
  input  logic [$clog2(DEPTH)-1:0] res_tag,
  input  logic                     res_taken,
  output logic                     update_valid,
  output logic [PC_W-1:0]          update_pc,
  output logic                     actual_taken,
  output logic                     mispredict
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  // Entry storage
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_resolved;
  logic [DEPTH-1:0] r_pred;
  logic [DEPTH-1:0] r_actual;
  logic [PC_W-1:0]  r_pc [DEPTH];

  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CNT_W-1:0] r_count;

  // Registered training outputs
  logic             r_update_valid;
  logic [PC_W-1:0]  r_update_pc;
  logic             r_actual_taken;
  logic             r_mispredict;

  logic w_full;
  logic w_retire;
  logic w_head_mis;
  logic w_flush;
  logic w_alloc;
  logic w_resolve;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  // The head retires only once its resolved bit is registered, so a resolve
  // never bypasses straight into retirement.
  assign w_retire   = r_valid[r_head] & r_resolved[r_head];
  assign w_head_mis = r_pred[r_head] ^ r_actual[r_head];

`ifdef BRQ_MISPRED_FLUSH_EN
  assign w_flush = w_retire & w_head_mis;
`else
  assign w_flush = 1'b0;
`endif

  // A same-cycle retirement does not free a slot while full.
  assign alloc_ready = ~w_full & ~w_flush;
  assign alloc_tag   = r_tail;
  assign w_alloc     = alloc_valid & alloc_ready;

  // Resolves to empty or already-resolved slots are dropped.
  assign w_resolve   = res_valid & ~w_flush & r_valid[res_tag] & ~r_resolved[res_tag];

  assign update_valid = r_update_valid;
  assign update_pc    = r_update_pc;
  assign actual_taken = r_actual_taken;
  assign mispredict   = r_mispredict;

  // Allocation writes the tail, which is never valid when allocation is
  // allowed. Resolution needs a valid, unresolved slot, and retirement needs
  // a resolved head, so the three writers never touch the same entry in one
  // cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= '0;
      r_resolved     <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_update_valid <= 1'b0;
      r_update_pc    <= '0;
      r_actual_taken <= 1'b0;
      r_mispredict   <= 1'b0;
    end else begin
      r_update_valid <= w_retire;
      r_mispredict   <= w_retire & w_head_mis;
      if (w_retire) begin
        r_update_pc    <= r_pc[r_head];
        r_actual_taken <= r_actual[r_head];
      end

      if (w_flush) begin
        r_valid    <= '0;
        r_resolved <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
      end else begin
        if (w_alloc) begin
          r_valid[r_tail]    <= 1'b1;
          r_resolved[r_tail] <= 1'b0;
          r_pc[r_tail]       <= alloc_pc;
          r_pred[r_tail]     <= alloc_pred_taken;
          r_actual[r_tail]   <= 1'b0;
          r_tail             <= r_tail + AW'(1);
        end

        if (w_resolve) begin
          r_resolved[res_tag] <= 1'b1;
          r_actual[res_tag]   <= res_taken;
        end

        if (w_retire) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + AW'(1);
        end

        case ({w_alloc, w_retire})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
